// File: rtl/ifetch32_if.sv
// ifetch32_if: groups the instruction-memory handshake with the issue and branch/link signals
// that pass between ifetch32 (master) and its neighbours (slave).
interface ifetch32_if;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic        stall;
   logic        ib;
   logic [31:0] bv;
   logic        bl;
   logic [31:0] iout;
   logic        ivalid;
   logic [31:0] pc_out;
   logic        lr_we;
   logic [31:0] lr_out;

   modport master (
      output imem_addr, imem_req, iout, ivalid, pc_out, lr_we, lr_out,
      input  imem_ack, imem_data, stall, ib, bv, bl
   );

   modport slave (
      input  imem_addr, imem_req, iout, ivalid, pc_out, lr_we, lr_out,
      output imem_ack, imem_data, stall, ib, bv, bl
   );
endinterface

// File: rtl/ifetch32.sv
// ifetch32: PC, req/ack fetch FSM, prefetch FIFO, branch redirect/flush and link write.
// Define IFETCH_PERFCNT_EN to add the saturating bubble_cnt output.
module ifetch32 #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2,
   parameter logic [31:0] NOP_WORD  = 32'hE1A0_0000
) (
   input  logic       clk,
   input  logic       rst,
   ifetch32_if.master bus
`ifdef IFETCH_PERFCNT_EN
   ,
   output logic [31:0] bubble_cnt
`endif
);
   localparam int AW = $clog2(BUF_DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(BUF_DEPTH);

   typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN} state_t;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } entry_t;

   state_t                 state_q, state_d;
   entry_t [BUF_DEPTH-1:0] mem_q, mem_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [AW:0]            count_q, count_d;
   logic [31:0]            fetch_pc_q, fetch_pc_d;
   logic [31:0]            last_pc_q, last_pc_d;
   logic [31:0]            drain_addr_q, drain_addr_d;
   logic [31:0]            lr_out_q, lr_out_d;
   logic                   lr_we_q, lr_we_d;
   logic                   ivalid, pop, push, link;
   logic [31:0]            target;
   entry_t                 head;

   assign head   = mem_q[rd_ptr_q];
   assign ivalid = (count_q != '0);
   assign pop    = ivalid & ~bus.stall & ~bus.ib;
   assign push   = (state_q == S_REQ) & bus.imem_ack & ~bus.ib;
   assign link   = bus.ib & bus.bl;
   assign target = last_pc_q + 32'd8 + bus.bv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_REQ;
      else     state_q <= state_d;
   end

   // A redirect never moves the address of an outstanding request; DRAIN finishes it first.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_REQ: begin
            if (bus.ib)                state_d = bus.imem_ack ? S_REQ : S_DRAIN;
            else if (count_d == FULL)  state_d = S_HOLD;
         end
         S_HOLD:  if (bus.ib || pop) state_d = S_REQ;
         S_DRAIN: if (bus.imem_ack)  state_d = S_REQ;
         default: state_d = S_REQ;
      endcase
   end

   always_comb begin
      bus.imem_req  = 1'b0;
      bus.imem_addr = fetch_pc_q;
      case (state_q)
         S_REQ:   bus.imem_req = ~rst;
         S_DRAIN: begin
            bus.imem_req  = ~rst;
            bus.imem_addr = drain_addr_q;
         end
         default: bus.imem_req = 1'b0;
      endcase
      bus.ivalid = ivalid;
      bus.iout   = ivalid ? head.word : NOP_WORD;
      bus.pc_out = ivalid ? head.pc : 32'd0;
      bus.lr_we  = lr_we_q;
      bus.lr_out = lr_out_q;
   end

   always_comb begin
      mem_d        = mem_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      fetch_pc_d   = fetch_pc_q;
      last_pc_d    = last_pc_q;
      drain_addr_d = drain_addr_q;
      lr_we_d      = link;
      lr_out_d     = link ? last_pc_q + 32'd4 : lr_out_q;
      if (bus.ib) begin
         // Flush: the head is squashed, not popped, so last_pc stays put.
         rd_ptr_d   = wr_ptr_q;
         count_d    = '0;
         fetch_pc_d = target;
         if (state_q == S_REQ) drain_addr_d = fetch_pc_q;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q].pc   = fetch_pc_q;
            mem_d[wr_ptr_q].word = bus.imem_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
            fetch_pc_d           = fetch_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            last_pc_d = head.pc;
         end
         count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q        <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         fetch_pc_q   <= RESET_PC;
         last_pc_q    <= RESET_PC;
         drain_addr_q <= RESET_PC;
         lr_we_q      <= 1'b0;
         lr_out_q     <= 32'd0;
      end else begin
         mem_q        <= mem_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         fetch_pc_q   <= fetch_pc_d;
         last_pc_q    <= last_pc_d;
         drain_addr_q <= drain_addr_d;
         lr_we_q      <= lr_we_d;
         lr_out_q     <= lr_out_d;
      end
   end

`ifdef IFETCH_PERFCNT_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (!ivalid && !bus.stall && bubble_cnt_q != 32'hFFFF_FFFF)
         bubble_cnt_d = bubble_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) bubble_cnt_q <= 32'd0;
      else     bubble_cnt_q <= bubble_cnt_d;
   end

   assign bubble_cnt = bubble_cnt_q;
`endif
endmodule
